// File: rtl/branch_pkg.sv
// Shared types for the branch predictor update path.
// Entry layout and PC width used by the resolve tracker and its queue.
package branch_pkg;

    localparam int BR_PC_NBITS = 32;

    typedef struct packed {
        logic [BR_PC_NBITS-1:0] pc;
        logic                   taken;
    } branch_entry_t;

endpackage

// File: rtl/branch_resolve_tracker_queue.sv
// In-order circular buffer of issued branch predictions.
// A clear empties the queue by snapping head onto the current tail.
module branch_resolve_tracker_queue
    import branch_pkg::*;
#(
    parameter int NUM_ENTRIES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enq_val,
    output logic          enq_rdy,
    input  branch_entry_t enq_data,
    input  logic          deq_val,
    output logic          deq_rdy,
    output branch_entry_t deq_data,
    input  logic          clear,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(NUM_ENTRIES);
    localparam int CW = PW + 1;

    branch_entry_t mem_q [NUM_ENTRIES];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          enq_fire;
    logic          deq_fire;

    assign full     = (cnt_q == CW'(NUM_ENTRIES));
    assign empty    = (cnt_q == '0);
    assign enq_rdy  = !full;
    assign deq_rdy  = !empty;
    assign deq_data = mem_q[head_q];

    // An enqueue landing in a flush cycle is wrong-path and dropped.
    assign enq_fire = enq_val && !full && !clear;
    assign deq_fire = deq_val && !empty;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clear) begin
            head_d = tail_q;
            cnt_d  = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + 1'b1;
            if (deq_fire) head_d = head_q + 1'b1;
            cnt_d = cnt_q + CW'(enq_fire) - CW'(deq_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[tail_q] <= enq_data;
    end

endmodule

// File: rtl/branch_resolve_tracker.sv
// Retires in-flight predictions against resolved outcomes and drives predictor updates.
// Statistics counters are built only when BRANCH_RESOLVE_TRACKER_STATS_EN is defined.
module branch_resolve_tracker
    import branch_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int CNT_NBITS   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pred_val,
    output logic                   pred_rdy,
    input  logic [BR_PC_NBITS-1:0] pred_pc,
    input  logic                   pred_taken,
    input  logic                   resolve_val,
    output logic                   resolve_rdy,
    input  logic                   resolve_taken,
    output logic                   update_en,
    output logic                   update_val,
    output logic                   mispredict,
    output logic [BR_PC_NBITS-1:0] mispredict_pc,
    output logic [CNT_NBITS-1:0]   total_count,
    output logic [CNT_NBITS-1:0]   mispred_count
);

    branch_entry_t enq_entry;
    branch_entry_t head_entry;
    logic          full;
    logic          empty;
    logic          fire;
    logic          miss;

    logic                   update_en_q;
    logic                   update_val_q;
    logic                   mispredict_q;
    logic [BR_PC_NBITS-1:0] mispredict_pc_q;

    assign enq_entry = '{pc: pred_pc, taken: pred_taken};

    branch_resolve_tracker_queue #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (pred_val),
        .enq_rdy  (pred_rdy),
        .enq_data (enq_entry),
        .deq_val  (resolve_val),
        .deq_rdy  (resolve_rdy),
        .deq_data (head_entry),
        .clear    (fire && miss),
        .full     (full),
        .empty    (empty)
    );

    assign fire = resolve_val && !empty;
    assign miss = (head_entry.taken != resolve_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            update_en_q     <= 1'b0;
            update_val_q    <= 1'b0;
            mispredict_q    <= 1'b0;
            mispredict_pc_q <= '0;
        end else begin
            update_en_q  <= fire;
            update_val_q <= fire && resolve_taken;
            mispredict_q <= fire && miss;
            if (fire && miss) mispredict_pc_q <= head_entry.pc;
        end
    end

    assign update_en     = update_en_q;
    assign update_val    = update_val_q;
    assign mispredict    = mispredict_q;
    assign mispredict_pc = mispredict_pc_q;

`ifdef BRANCH_RESOLVE_TRACKER_STATS_EN
    logic [CNT_NBITS-1:0] total_q;
    logic [CNT_NBITS-1:0] mispred_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q   <= '0;
            mispred_q <= '0;
        end else if (fire) begin
            total_q   <= total_q + 1'b1;
            mispred_q <= mispred_q + CNT_NBITS'(miss);
        end
    end

    assign total_count   = total_q;
    assign mispred_count = mispred_q;
`else
    assign total_count   = '0;
    assign mispred_count = '0;
`endif

    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Scoreboard bench for branch_resolve_tracker.
// Counter expectations follow BRANCH_RESOLVE_TRACKER_STATS_EN.
module tb_branch_resolve_tracker;
    import branch_pkg::*;

    localparam int N  = 4;
    localparam int CN = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          pred_val;
    logic          pred_rdy;
    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic          resolve_val;
    logic          resolve_rdy;
    logic          resolve_taken;
    logic          update_en;
    logic          update_val;
    logic          mispredict;
    logic [31:0]   mispredict_pc;
    logic [CN-1:0] total_count;
    logic [CN-1:0] mispred_count;

    branch_resolve_tracker #(
        .NUM_ENTRIES(N),
        .CNT_NBITS  (CN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pred_val     (pred_val),
        .pred_rdy     (pred_rdy),
        .pred_pc      (pred_pc),
        .pred_taken   (pred_taken),
        .resolve_val  (resolve_val),
        .resolve_rdy  (resolve_rdy),
        .resolve_taken(resolve_taken),
        .update_en    (update_en),
        .update_val   (update_val),
        .mispredict   (mispredict),
        .mispredict_pc(mispredict_pc),
        .total_count  (total_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        val;
        logic        mis;
        logic [31:0] pc;
    } exp_t;

    branch_entry_t mq[$];
    exp_t          sb[$];
    logic [31:0]   m_mpc;
    int            m_tot;
    int            m_mis;
    int            checks;
    int            errors;
    int            n_upd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic pv, input logic [31:0] pc,
                       input logic pt, input logic rv, input logic rt);
        branch_entry_t e;
        exp_t          x;
        logic          efire;
        @(negedge clk);
        reset         = rst;
        pred_val      = pv;
        pred_pc       = pc;
        pred_taken    = pt;
        resolve_val   = rv;
        resolve_taken = rt;
        if (!rst) begin
            check("pred_rdy", 32'(pred_rdy), 32'(mq.size() < N));
            check("resolve_rdy", 32'(resolve_rdy), 32'(mq.size() > 0));
        end
        if (rst) begin
            mq.delete();
            sb.delete();
            m_mpc = '0;
            m_tot = 0;
            m_mis = 0;
        end else begin
            efire = pv && (mq.size() < N);
            if (rv && mq.size() > 0) begin
                e     = mq.pop_front();
                x.val = rt;
                x.mis = (e.taken != rt);
                x.pc  = e.pc;
                sb.push_back(x);
                m_tot++;
                if (x.mis) begin
                    m_mis++;
                    m_mpc = e.pc;
                    mq.delete();
                    efire = 1'b0;
                end
            end
            if (efire) mq.push_back('{pc: pc, taken: pt});
        end
        @(posedge clk);
        #1;
        reset       = 1'b0;
        pred_val    = 1'b0;
        resolve_val = 1'b0;
        check("update_en", 32'(update_en), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            x = sb.pop_front();
            n_upd++;
            check("update_val", 32'(update_val), 32'(x.val));
            check("mispredict", 32'(mispredict), 32'(x.mis));
        end else begin
            check("update_val_idle", 32'(update_val), 32'd0);
            check("mispredict_idle", 32'(mispredict), 32'd0);
        end
        check("mispredict_pc", mispredict_pc, m_mpc);
`ifdef BRANCH_RESOLVE_TRACKER_STATS_EN
        check("total_count", total_count, 32'(m_tot));
        check("mispred_count", mispred_count, 32'(m_mis));
`else
        check("total_count", total_count, 32'd0);
        check("mispred_count", mispred_count, 32'd0);
`endif
    endtask

    task automatic enq(input logic [31:0] pc, input logic pt);
        cyc(1'b0, 1'b1, pc, pt, 1'b0, 1'b0);
    endtask

    task automatic res(input logic rt);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, rt);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_upd  = 0;
        m_mpc  = '0;
        m_tot  = 0;
        m_mis  = 0;
        reset = 1'b1;
        pred_val = 1'b0;
        pred_pc = '0;
        pred_taken = 1'b0;
        resolve_val = 1'b0;
        resolve_taken = 1'b0;

        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();

        enq(32'h100, 1'b1);
        res(1'b1);
        idle();

        enq(32'h200, 1'b0);
        res(1'b1);
        idle();

        res(1'b0);
        for (int i = 0; i < 5; i++) enq(32'h300 + 32'(i * 4), 1'(i & 1));
        res(1'b0);
        idle();
        res(1'b1);
        res(1'b0);
        res(1'b1);
        idle();

        enq(32'h10, 1'b1);
        enq(32'h14, 1'b1);
        enq(32'h18, 1'b0);
        cyc(1'b0, 1'b1, 32'h1c, 1'b1, 1'b1, 1'b0);
        idle();
        res(1'b1);

        n_upd = 0;
        for (int i = 0; i < 10; i++) begin
            enq(32'h400 + 32'(i * 4), 1'(i & 1));
            res(1'(i & 1));
        end
        check("wrap_updates", 32'(n_upd), 32'd10);

        enq(32'h500, 1'b1);
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, 32'h504 + 32'(i * 4), 1'(i & 1), 1'b1, 1'(~i & 1));
        res(1'b0);
        idle();

        enq(32'h600, 1'b1);
        enq(32'h604, 1'b0);
        enq(32'h608, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        enq(32'h700, 1'b0);
        res(1'b1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
